pc_mem_unit: RTL and testbench

PC_MEM_UNIT -- requirements
Module: pc_mem_unit

---
 rtl/pc_mem_unit_pkg.sv | 22 ++
 rtl/pc_mem_unit_pc_next.sv | 34 +++
 rtl/pc_mem_unit.sv | 109 ++++++++++
 tb/tb_pc_mem_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_mem_unit_pkg.sv
// Shared encodings for the PC / memory sequencing unit: memory commands,
// next-PC select modes and the controller state enum.
package pc_mem_unit_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [1:0] SEL_NEXT = 2'd0;
  localparam logic [1:0] SEL_REL  = 2'd1;
  localparam logic [1:0] SEL_ABS  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/pc_mem_unit_pc_next.sv
// Combinational next-PC generator; all arithmetic wraps modulo 2^ADDR_W.
module pc_next
  import pc_mem_unit_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] off,
  input  logic [DATA_W-1:0] target,
  output logic [ADDR_W-1:0] next
);

  logic [ADDR_W-1:0] off_w;
  logic [ADDR_W-1:0] target_w;
  logic [ADDR_W-1:0] pc_inc;

  // Signed size cast sign-extends a narrow offset or truncates a wide one.
  assign off_w    = ADDR_W'($signed(off));
  assign target_w = ADDR_W'(target);
  assign pc_inc   = pc + ADDR_W'(1);

  always_comb begin
    next = pc;
    case (sel)
      SEL_NEXT: next = pc_inc;
      SEL_REL:  next = pc_inc + off_w;
      SEL_ABS:  next = target_w;
      default:  next = pc;
    endcase
  end

endmodule

// File: rtl/pc_mem_unit.sv
// Fetch / execute sequencer sharing one memory port between instruction
// fetches and execute-stage data accesses.
module pc_mem_unit
  import pc_mem_unit_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_done,
  output logic [DATA_W-1:0] ex_rdata,
  input  logic              pc_update,
  input  logic [1:0]        pc_sel,
  input  logic [DATA_W-1:0] pc_off,
  input  logic [DATA_W-1:0] pc_abs,
  input  logic              halt,
  output logic              halted,
  output logic [2:0]        fsm_state
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_we;

  pc_next #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pc_next (
    .pc     (pc),
    .sel    (pc_sel),
    .off    (pc_off),
    .target (pc_abs),
    .next   (pc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= ADDR_W'(RESET_PC);
      ir       <= '0;
      ex_rdata <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      ex_done  <= 1'b0;
    end else begin
      state   <= state_n;
      ex_done <= (state == ST_MEM) && mem_ready;
      case (state)
        ST_FETCH: if (mem_ready) ir <= read_data;
        ST_EXEC: begin
          // A data request wins over a simultaneous retire; the retire is dropped.
          if (ex_req) begin
            lat_addr <= ADDR_W'(ex_addr);
            lat_data <= ex_wdata;
            lat_we   <= ex_we;
          end else if (pc_update) begin
            pc <= pc_nxt;
          end
        end
        ST_MEM: if (mem_ready && !lat_we) ex_rdata <= read_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    mem_cmd  = CMD_NONE;
    mem_addr = pc;
    case (state)
      ST_IDLE: if (start) state_n = ST_FETCH;
      ST_FETCH: begin
        mem_cmd = CMD_READ;
        if (mem_ready) state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (ex_req)         state_n = ST_MEM;
        else if (pc_update) state_n = halt ? ST_HALT : ST_FETCH;
      end
      ST_MEM: begin
        mem_cmd  = lat_we ? CMD_WRITE : CMD_READ;
        mem_addr = lat_addr;
        if (mem_ready) state_n = ST_EXEC;
      end
      default: state_n = state;
    endcase
  end

  assign write_data = lat_data;
  assign ir_valid   = (state == ST_EXEC);
  assign halted     = (state == ST_HALT);
  assign fsm_state  = state;

endmodule

// File: tb/tb_pc_mem_unit.sv
// Self-checking bench for pc_mem_unit: directed scenarios plus a randomized
// run checked against a plain-arithmetic PC and data model.
module tb_pc_mem_unit;
  import pc_mem_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready, ex_req, ex_we, pc_update, halt;
  logic [1:0]  mem_cmd, pc_sel;
  logic [8:0]  mem_addr, pc;
  logic [15:0] write_data, read_data, ir, ex_addr, ex_wdata, ex_rdata, pc_off, pc_abs;
  logic        ir_valid, ex_done, halted;
  logic [2:0]  fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  pc_mem_unit dut (
    .clk(clk), .reset(reset), .start(start), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .mem_ready(mem_ready), .read_data(read_data), .ir(ir),
    .ir_valid(ir_valid), .pc(pc), .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_done(ex_done), .ex_rdata(ex_rdata), .pc_update(pc_update),
    .pc_sel(pc_sel), .pc_off(pc_off), .pc_abs(pc_abs), .halt(halt), .halted(halted),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; ex_req = 1'b0; ex_we = 1'b0;
    pc_update = 1'b0; halt = 1'b0; pc_sel = SEL_NEXT; pc_off = '0; pc_abs = '0;
    ex_addr = '0; ex_wdata = '0; read_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic kick_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic mem_respond(input logic [15:0] data);
    mem_ready = 1'b1;
    read_data = data;
    tick();
    mem_ready = 1'b0;
    read_data = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic retire(input logic [1:0] sel, input logic [15:0] off,
                        input logic [15:0] tgt, input logic h);
    pc_update = 1'b1; pc_sel = sel; pc_off = off; pc_abs = tgt; halt = h;
    tick();
    pc_update = 1'b0; halt = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    ex_req = 1'b1; ex_we = we; ex_addr = addr; ex_wdata = wd;
    tick();
    ex_req = 1'b0;
  endtask

  // Reference next-PC rule, in integer arithmetic wrapped to the 9-bit space.
  function automatic int model_next(int cur, logic [1:0] sel, logic [15:0] off, logic [15:0] tgt);
    int t;
    int soff;
    soff = $signed(off);
    case (sel)
      2'd0:    t = cur + 1;
      2'd1:    t = cur + 1 + soff;
      2'd2:    t = int'(tgt) % 512;
      default: t = cur;
    endcase
    return ((t % 512) + 512) % 512;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    n_cmp++; if (mem_cmd !== CMD_NONE) begin n_err++; $display("FAIL reset_cmd got=%0h exp=0", mem_cmd); end
    n_cmp++; if (pc !== 9'd0) begin n_err++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    n_cmp++; if (ir !== 16'd0 || ex_rdata !== 16'd0 || write_data !== 16'd0)
      begin n_err++; $display("FAIL reset_regs ir=%0h rdata=%0h wdata=%0h exp=0", ir, ex_rdata, write_data); end
    n_cmp++; if ({ir_valid, ex_done, halted} !== 3'b000)
      begin n_err++; $display("FAIL reset_flags got=%b exp=000", {ir_valid, ex_done, halted}); end
    n_cmp++; if (fsm_state !== 3'(ST_IDLE)) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
    // Retire and data requests must be ignored while idle.
    retire(SEL_ABS, 16'h0, 16'h0077, 1'b0);
    data_req(1'b1, 16'h0033, 16'h5555);
    n_cmp++; if (pc !== 9'd0 || mem_cmd !== CMD_NONE || fsm_state !== 3'(ST_IDLE))
      begin n_err++; $display("FAIL idle_ignore pc=%0h cmd=%0h st=%0d exp=0/0/idle", pc, mem_cmd, fsm_state); end
  endtask

  task automatic test_fetch();
    mem_ready = 1'b1; read_data = 16'h1234;
    kick_start();
    n_cmp++; if (mem_cmd !== CMD_READ || mem_addr !== 9'd0)
      begin n_err++; $display("FAIL fetch_cmd cmd=%0h addr=%0h exp=1/0", mem_cmd, mem_addr); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fetch_early_valid got=%b exp=0", ir_valid); end
    tick();
    mem_ready = 1'b0;
    n_cmp++; if (ir !== 16'h1234 || ir_valid !== 1'b1)
      begin n_err++; $display("FAIL fetch_ir ir=%0h valid=%b exp=1234/1", ir, ir_valid); end
  endtask

  task automatic test_data_write();
    int pulses;
    pulses = 0;
    data_req(1'b1, 16'h0105, 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem_cmd !== CMD_WRITE || mem_addr !== 9'h105 || write_data !== 16'hBEEF)
        begin n_err++; $display("FAIL write_hold cyc=%0d cmd=%0h addr=%0h wd=%0h exp=2/105/beef", k, mem_cmd, mem_addr, write_data); end
      if (ex_done) pulses++;
      if (k == 3) mem_respond(16'hDEAD); else tick();
    end
    if (ex_done) pulses++;
    n_cmp++; if (ir_valid !== 1'b1 || mem_cmd !== CMD_NONE)
      begin n_err++; $display("FAIL write_return valid=%b cmd=%0h exp=1/0", ir_valid, mem_cmd); end
    tick();
    if (ex_done) pulses++;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL write_done_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (ex_rdata !== 16'h0) begin n_err++; $display("FAIL write_no_rdata got=%0h exp=0", ex_rdata); end
  endtask

  task automatic test_pc_rules();
    retire(SEL_ABS, 16'h0, 16'h01FF, 1'b0);
    n_cmp++; if (pc !== 9'h1FF) begin n_err++; $display("FAIL pc_abs_1ff got=%0h exp=1ff", pc); end
    mem_respond(16'h1111);
    retire(SEL_NEXT, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (pc !== 9'h000 || mem_cmd !== CMD_READ || mem_addr !== 9'h000)
      begin n_err++; $display("FAIL pc_wrap pc=%0h cmd=%0h addr=%0h exp=0/1/0", pc, mem_cmd, mem_addr); end
    mem_respond(16'h2222);
    retire(SEL_ABS, 16'h0, 16'h0005, 1'b0);
    mem_respond(16'h3333);
    retire(SEL_REL, 16'hFFFD, 16'h0, 1'b0);
    n_cmp++; if (pc !== 9'h003) begin n_err++; $display("FAIL pc_rel_neg got=%0h exp=3", pc); end
    mem_respond(16'h4444);
    retire(SEL_ABS, 16'h0, 16'hFE10, 1'b0);
    n_cmp++; if (pc !== 9'h010 || mem_addr !== 9'h010)
      begin n_err++; $display("FAIL pc_abs_trunc pc=%0h addr=%0h exp=10", pc, mem_addr); end
    mem_respond(16'h5555);
    retire(SEL_HOLD, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (pc !== 9'h010 || mem_cmd !== CMD_READ)
      begin n_err++; $display("FAIL pc_hold pc=%0h cmd=%0h exp=10/1", pc, mem_cmd); end
    mem_respond(16'h6666);
  endtask

  task automatic test_priority();
    logic [8:0] p0;
    p0 = pc;
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 16'h00AB; pc_update = 1'b1; pc_sel = SEL_NEXT;
    tick();
    ex_req = 1'b0; pc_update = 1'b0;
    n_cmp++; if (fsm_state !== 3'(ST_MEM) || pc !== p0 || mem_cmd !== CMD_READ || mem_addr !== 9'h0AB)
      begin n_err++; $display("FAIL prio_mem st=%0d pc=%0h cmd=%0h addr=%0h exp=mem/%0h/1/ab", fsm_state, pc, mem_cmd, mem_addr, p0); end
    mem_respond(16'hCAFE);
    n_cmp++; if (ex_done !== 1'b1 || ex_rdata !== 16'hCAFE)
      begin n_err++; $display("FAIL prio_load done=%b rdata=%0h exp=1/cafe", ex_done, ex_rdata); end
    retire(SEL_NEXT, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (pc !== p0 + 9'd1 || mem_cmd !== CMD_READ || mem_addr !== p0 + 9'd1)
      begin n_err++; $display("FAIL prio_commit pc=%0h cmd=%0h exp=%0h/1", pc, mem_cmd, p0 + 9'd1); end
    mem_respond(16'h7777);
  endtask

  task automatic test_random();
    int exp_pc;
    logic [15:0] exp_rdata;
    logic we, h;
    logic [15:0] a, wd, rd, off, tgt;
    logic [1:0] sel;
    int dly;
    reset_dut();
    exp_pc = 0;
    exp_rdata = '0;
    kick_start();
    mem_respond(16'h0F0F);
    for (int i = 0; i < 60; i++) begin
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) begin
        we = 1'($urandom); a = 16'($urandom); wd = 16'($urandom); rd = 16'($urandom);
        data_req(we, a, wd);
        idle_cycles(dly);
        n_cmp++; if (mem_cmd !== (we ? CMD_WRITE : CMD_READ) || mem_addr !== a[8:0] || write_data !== wd || pc !== 9'(exp_pc))
          begin n_err++; $display("FAIL rnd_data i=%0d cmd=%0h addr=%0h wd=%0h pc=%0h exp_addr=%0h exp_pc=%0h", i, mem_cmd, mem_addr, write_data, pc, a[8:0], exp_pc); end
        mem_respond(rd);
        if (!we) exp_rdata = rd;
        n_cmp++; if (ex_done !== 1'b1 || ex_rdata !== exp_rdata || ir_valid !== 1'b1)
          begin n_err++; $display("FAIL rnd_done i=%0d done=%b rdata=%0h exp=%0h", i, ex_done, ex_rdata, exp_rdata); end
      end else begin
        sel = 2'($urandom); off = 16'($urandom); tgt = 16'($urandom); rd = 16'($urandom);
        if ($urandom_range(0, 3) == 0) off = 16'($signed($urandom_range(0, 8)) - 4);
        exp_pc = model_next(exp_pc, sel, off, tgt);
        exp_q.push_back(16'(exp_pc));
        exp_q.push_back(rd);
        retire(sel, off, tgt, 1'b0);
        idle_cycles(dly);
        n_cmp++; if (mem_cmd !== CMD_READ || {7'd0, mem_addr} !== exp_q.pop_front() || pc !== 9'(exp_pc))
          begin n_err++; $display("FAIL rnd_fetch i=%0d sel=%0d cmd=%0h addr=%0h pc=%0h exp=%0h", i, sel, mem_cmd, mem_addr, pc, exp_pc); end
        mem_respond(rd);
        n_cmp++; if (ir !== exp_q.pop_front() || ir_valid !== 1'b1)
          begin n_err++; $display("FAIL rnd_ir i=%0d ir=%0h exp=%0h", i, ir, rd); end
      end
      h = 1'b0;
      n_cmp++; if (halted !== h || ex_done !== 1'b0 && i < 0)
        begin n_err++; $display("FAIL rnd_halted i=%0d got=%b exp=0", i, halted); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    retire(SEL_ABS, 16'h0, 16'h0123, 1'b0);
    tick();
    n_cmp++; if (mem_cmd !== CMD_READ || mem_addr !== 9'h123)
      begin n_err++; $display("FAIL midfetch_pre cmd=%0h addr=%0h exp=1/123", mem_cmd, mem_addr); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (mem_cmd !== CMD_NONE || fsm_state !== 3'(ST_IDLE) || pc !== 9'd0 || ir_valid !== 1'b0)
      begin n_err++; $display("FAIL midfetch_abort cmd=%0h st=%0d pc=%0h exp=0/idle/0", mem_cmd, fsm_state, pc); end
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (ir !== 16'h0) begin n_err++; $display("FAIL midfetch_ir got=%0h exp=0", ir); end
  endtask

  task automatic test_halt();
    kick_start();
    mem_respond(16'h0ABC);
    retire(SEL_NEXT, 16'h0, 16'h0, 1'b1);
    n_cmp++; if (halted !== 1'b1 || mem_cmd !== CMD_NONE || pc !== 9'd1)
      begin n_err++; $display("FAIL halt_enter halted=%b cmd=%0h pc=%0h exp=1/0/1", halted, mem_cmd, pc); end
    start = 1'b1; ex_req = 1'b1; ex_we = 1'b1; pc_update = 1'b1; pc_sel = SEL_NEXT; mem_ready = 1'b1;
    idle_cycles(4);
    start = 1'b0; ex_req = 1'b0; pc_update = 1'b0; mem_ready = 1'b0;
    n_cmp++; if (halted !== 1'b1 || mem_cmd !== CMD_NONE || pc !== 9'd1 || ex_done !== 1'b0)
      begin n_err++; $display("FAIL halt_sticky halted=%b cmd=%0h pc=%0h done=%b exp=1/0/1/0", halted, mem_cmd, pc, ex_done); end
    reset_dut();
    n_cmp++; if (halted !== 1'b0 || fsm_state !== 3'(ST_IDLE))
      begin n_err++; $display("FAIL halt_reset halted=%b st=%0d exp=0/idle", halted, fsm_state); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_write();
    test_pc_rules();
    test_priority();
    test_reset_mid_fetch();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
